// File: rtl/cw_capture_reader.sv
// cw_capture_reader: circular capture buffer for ChipWatcher samples, dumped oldest-first as
// bytes over valid/ready. Define CW_RD_HEADER_EN to prefix each dump with A5/count header bytes.
module cw_capture_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_ce,
  input  logic              wt_en,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              cap_clr,
  input  logic              rd_start,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [ADDR_W:0]   smp_count
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StHdr, StFetch, StSend} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
  logic [ADDR_W:0]     r_remain, w_remain_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_src, w_src_nxt;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [ADDR_W:0]     r_smp_count;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_ram_q;
  logic                w_wr;
`ifdef CW_RD_HEADER_EN
  logic [7:0]          r_hdr, w_hdr_nxt;
  logic [1:0]          r_hdr_idx, w_hdr_idx_nxt;
  logic [15:0]         w_cnt16;

  assign w_cnt16 = 16'(r_smp_count);
  assign tx_data = r_src ? r_ram_q : r_hdr;
`else
  assign tx_data = r_src ? r_ram_q : '0;
`endif

  assign w_wr      = wt_ce & wt_en & ~r_busy;
  assign tx_valid  = r_valid;
  assign busy      = r_busy;
  assign smp_count = r_smp_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_addr <= '0;
      r_smp_count <= '0;
    end else begin
      if (w_wr) r_last_addr <= wt_addr;
      if (cap_clr && !r_busy) begin
        r_smp_count <= w_wr ? (ADDR_W+1)'(1) : '0;
      end else if (w_wr && (r_smp_count != CNT_FULL)) begin
        r_smp_count <= r_smp_count + (ADDR_W+1)'(1);
      end
    end
  end

  // Sample RAM is not reset; r_ram_q only reaches tx_data once r_src is set.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[wt_addr] <= wt_data;
    if (r_state == StFetch) r_ram_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rd_ptr <= '0;
      r_remain <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_src    <= 1'b0;
`ifdef CW_RD_HEADER_EN
      r_hdr     <= '0;
      r_hdr_idx <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_remain <= w_remain_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_src    <= w_src_nxt;
`ifdef CW_RD_HEADER_EN
      r_hdr     <= w_hdr_nxt;
      r_hdr_idx <= w_hdr_idx_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_ptr_nxt = r_rd_ptr;
    w_remain_nxt = r_remain;
    w_valid_nxt  = r_valid;
    w_busy_nxt   = r_busy;
    w_src_nxt    = r_src;
`ifdef CW_RD_HEADER_EN
    w_hdr_nxt     = r_hdr;
    w_hdr_idx_nxt = r_hdr_idx;
`endif
    unique case (r_state)
      StIdle: begin
        if (rd_start && (r_smp_count != '0)) begin
          w_state_nxt = StLoad;
          w_busy_nxt  = 1'b1;
        end
      end
      StLoad: begin
        w_remain_nxt = r_smp_count;
        // When full the low count bits are zero, so this also yields last_addr+1.
        w_rd_ptr_nxt = r_last_addr + ADDR_W'(1) - r_smp_count[ADDR_W-1:0];
`ifdef CW_RD_HEADER_EN
        w_state_nxt   = StHdr;
        w_valid_nxt   = 1'b1;
        w_src_nxt     = 1'b0;
        w_hdr_nxt     = 8'hA5;
        w_hdr_idx_nxt = 2'd0;
`else
        w_state_nxt = StFetch;
`endif
      end
`ifdef CW_RD_HEADER_EN
      StHdr: begin
        if (tx_ready) begin
          if (r_hdr_idx == 2'd2) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = StFetch;
          end else begin
            w_hdr_idx_nxt = r_hdr_idx + 2'd1;
            w_hdr_nxt     = (r_hdr_idx == 2'd0) ? w_cnt16[15:8] : w_cnt16[7:0];
          end
        end
      end
`endif
      StFetch: begin
        w_state_nxt = StSend;
        w_valid_nxt = 1'b1;
        w_src_nxt   = 1'b1;
      end
      StSend: begin
        if (tx_ready) begin
          w_valid_nxt  = 1'b0;
          w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
          w_remain_nxt = r_remain - (ADDR_W+1)'(1);
          if (r_remain == (ADDR_W+1)'(1)) begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = StFetch;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cw_capture_reader.sv
// Directed bench for cw_capture_reader (ADDR_W=4): dump order, wrap, back-pressure,
// frozen buffer, empty start and reset mid-dump; header bytes expected when CW_RD_HEADER_EN.
module tb_cw_capture_reader;
  localparam int unsigned AW = 4;
`ifdef CW_RD_HEADER_EN
  localparam int HDR_N = 3;
  localparam int FIRST_LAT = 2;
`else
  localparam int HDR_N = 0;
  localparam int FIRST_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wt_ce, wt_en, cap_clr, rd_start, tx_ready;
  logic [AW-1:0] wt_addr;
  logic [7:0]    wt_data;
  logic [7:0]    tx_data;
  logic          tx_valid, busy;
  logic [AW:0]   smp_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_b [32];
  logic [7:0] rx [64];
  int rx_n;

  cw_capture_reader #(.DATA_W(8), .ADDR_W(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wt_ce     (wt_ce),
    .wt_en     (wt_en),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .cap_clr   (cap_clr),
    .rd_start  (rd_start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .smp_count (smp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic clr);
    wt_ce = 1'b1; wt_en = 1'b1; wt_addr = a; wt_data = d; cap_clr = clr;
    step();
    wt_ce = 1'b0; wt_en = 1'b0; cap_clr = 1'b0;
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int n_samp);
    if (i >= HDR_N) return exp_b[i-HDR_N];
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h00;
    return 8'(n_samp);
  endfunction

  task automatic idle_probe(input string tag);
    int hits;
    hits = 0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (10) begin
      if (busy || tx_valid) hits++;
      step();
    end
    check(tag, hits, 0);
  endtask

  // rmode 0: tx_ready always high; 1: ready one cycle in three.
  // meddle: hammer writes and cap_clr while the dump runs.
  task automatic dump(input int n_samp, input int rmode, input bit meddle);
    int n_tot, first, unstable;
    bit pend;
    logic [7:0] last;
    n_tot = n_samp + HDR_N;
    rx_n = 0; first = -1; unstable = 0; pend = 1'b0; last = '0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int cyc = 1; cyc < 400 && rx_n < n_tot; cyc++) begin
      tx_ready = (rmode == 0) || (cyc % 3 == 1);
      if (meddle) begin
        wt_ce = 1'b1; wt_en = 1'b1; wt_addr = 4'd3; wt_data = 8'hEE; cap_clr = 1'b1;
      end
      if (tx_valid) begin
        if (first < 0) first = cyc;
        if (pend && tx_data !== last) unstable++;
        if (tx_ready) begin
          rx[rx_n] = tx_data;
          rx_n++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          last = tx_data;
        end
      end
      step();
    end
    tx_ready = 1'b0; wt_ce = 1'b0; wt_en = 1'b0; cap_clr = 1'b0;
    check("rx_count", rx_n, n_tot);
    check("first_valid", first, FIRST_LAT);
    check("data_stable", unstable, 0);
    check("busy_done", busy, 0);
    check("valid_done", tx_valid, 0);
    for (int i = 0; i < rx_n; i++) check("byte", rx[i], exp_byte(i, n_samp));
  endtask

  initial begin
    int nacc;
    bit found;
    rst = 1'b1; wt_ce = 0; wt_en = 0; wt_addr = '0; wt_data = '0;
    cap_clr = 0; rd_start = 0; tx_ready = 0;
    step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", smp_count, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    step();

    idle_probe("empty_rd_start");

    wr(4'd0, 8'h11, 1'b0);
    wr(4'd1, 8'h22, 1'b0);
    wr(4'd2, 8'h33, 1'b0);
    check("count3", smp_count, 3);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    dump(3, 0, 1'b0);
    check("count3_after", smp_count, 3);
    dump(3, 0, 1'b1);
    check("count_frozen", smp_count, 3);
    dump(3, 1, 1'b0);

    wr(4'd0, 8'h00, 1'b1);
    check("clr_and_write", smp_count, 1);
    for (int i = 1; i < 20; i++) wr(4'(i % 16), 8'(i), 1'b0);
    check("count_sat", smp_count, 16);
    for (int i = 0; i < 16; i++) exp_b[i] = 8'(i + 4);
    dump(16, 0, 1'b0);
    dump(16, 1, 1'b0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) wr(4'(i), 8'(8'h51 + i), 1'b0);
    rd_start = 1'b1;
    tx_ready = 1'b1;
    step();
    rd_start = 1'b0;
    nacc = 0;
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (tx_valid && nacc == 1) found = 1'b1;
      else begin
        if (tx_valid) nacc++;
        step();
      end
    end
    check("mid_second_byte", found, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", smp_count, 0);
    tx_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    idle_probe("after_rst_rd_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
